// File: rtl/harness_sequencer.sv
// Test-harness sequencer: CPU reset, program load, bounded CPU run, then one result byte read back.
// Optional HARNESS_SEQ_HALT_ON_RESULT_EN: a RUN-phase write to RESULT_ADDR ends the run early.
module harness_sequencer #(
    parameter int unsigned CPU_RST_CYCLES = 32'd8,
    parameter int unsigned SETTLE_CYCLES  = 32'd6,
    parameter int unsigned RUN_CYCLES     = 32'd2444,
    parameter int unsigned LOAD_MAX       = 32'd1024,
    parameter logic [15:0] RESULT_ADDR    = 16'hE200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] ld_addr,
    input  logic        ld_we,
    input  logic [7:0]  ld_data,
    input  logic        ld_done,
    output logic        ld_rst,
    output logic        ld_load,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_lh,
    output logic        cpu_reset,
    output logic        cpu_rdy,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic        ram_re,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic [7:0]  result,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CPURST = 3'd1,
        S_LOAD   = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_DUMP   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Last phase-counter value of each timed state (counter is 0 on a state's first cycle).
    localparam logic [31:0] RST_LAST    = 32'(CPU_RST_CYCLES) - 32'd1;
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES) - 32'd1;
    localparam logic [31:0] RUN_LAST    = 32'(RUN_CYCLES) - 32'd1;
    localparam logic [31:0] LOAD_LAST   = 32'(LOAD_MAX) - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  abl_q, abl_d;
    logic [7:0]  abh_q, abh_d;
    logic [7:0]  result_q, result_d;
    logic        error_q, error_d;
    logic        cap_q, cap_d;
    logic        ld_rst_q, ld_rst_d;
    logic        ld_load_q, ld_load_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        cpu_rdy_q, cpu_rdy_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0] cpu_addr_s;
    logic        we_g_s;
    logic        halt_s;

    assign cpu_addr_s = {abh_q, abl_q};
    assign we_g_s     = cpu_we & (cpu_lh == 3'd5) & cpu_rdy_q;

`ifdef HARNESS_SEQ_HALT_ON_RESULT_EN
    assign halt_s = we_g_s & (cpu_addr_s == RESULT_ADDR);
`else
    assign halt_s = 1'b0;
`endif

    // Next-state logic; a low start outside IDLE/DONE always aborts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CPURST;
                else       state_d = S_IDLE;
            end
            S_CPURST: begin
                if (!start)                 state_d = S_IDLE;
                else if (cnt_q == RST_LAST) state_d = S_LOAD;
                else                        state_d = S_CPURST;
            end
            S_LOAD: begin
                if (!start)                  state_d = S_IDLE;
                else if (ld_done)            state_d = S_SETTLE;
                else if (cnt_q == LOAD_LAST) state_d = S_DONE;
                else                         state_d = S_LOAD;
            end
            S_SETTLE: begin
                if (!start)                    state_d = S_IDLE;
                else if (cnt_q == SETTLE_LAST) state_d = S_RUN;
                else                           state_d = S_SETTLE;
            end
            S_RUN: begin
                if (!start)                           state_d = S_IDLE;
                else if (halt_s || cnt_q == RUN_LAST) state_d = S_DUMP;
                else                                  state_d = S_RUN;
            end
            S_DUMP: begin
                if (!start) state_d = S_IDLE;
                else        state_d = S_DONE;
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
                else        state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control/status outputs are registered from the next state so they align with state_q.
    always_comb begin
        ld_rst_d    = 1'b0;
        ld_load_d   = 1'b0;
        cpu_reset_d = 1'b0;
        cpu_rdy_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            S_IDLE: begin
                ld_rst_d    = 1'b1;
                cpu_reset_d = 1'b1;
            end
            S_CPURST: begin
                ld_rst_d    = 1'b1;
                cpu_reset_d = 1'b1;
                busy_d      = 1'b1;
            end
            S_LOAD: begin
                ld_load_d   = 1'b1;
                cpu_reset_d = 1'b1;
                busy_d      = 1'b1;
            end
            S_SETTLE: busy_d = 1'b1;
            S_RUN: begin
                cpu_rdy_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_DUMP: busy_d = 1'b1;
            S_DONE: done_d = 1'b1;
            default: begin
                ld_rst_d    = 1'b1;
                cpu_reset_d = 1'b1;
            end
        endcase
    end

    // Phase counter, address rebuild, error flag and result capture.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = 32'd0;
        end else if (cnt_q == 32'hFFFF_FFFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        if (state_q == S_IDLE || state_q == S_CPURST) begin
            abl_d = 8'h00;
            abh_d = 8'h00;
        end else begin
            if (cpu_lh == 3'd0) abl_d = cpu_do;
            else                abl_d = abl_q;
            if (cpu_lh == 3'd2) abh_d = cpu_do;
            else                abh_d = abh_q;
        end

        if (state_d == S_IDLE) begin
            error_d = 1'b0;
        end else if (state_q == S_LOAD && state_d == S_DONE) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end

        // Read data for the DUMP read arrives during the first DONE cycle.
        cap_d = (state_q == S_DUMP) && (state_d == S_DONE);
        if (cap_q) result_d = ram_dout;
        else       result_d = result_q;
    end

    // Single RAM port mux: loader in LOAD, CPU in RUN, result read in DUMP.
    always_comb begin
        ram_addr = 16'h0000;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_din  = 8'h00;
        case (state_q)
            S_LOAD: begin
                ram_addr = ld_addr;
                ram_we   = ld_we;
                ram_din  = ld_data;
            end
            S_RUN: begin
                ram_addr = cpu_addr_s;
                ram_we   = we_g_s;
                ram_re   = !we_g_s & (cpu_lh == 3'd3) & cpu_rdy_q;
                ram_din  = cpu_do;
            end
            S_DUMP: begin
                ram_addr = RESULT_ADDR;
                ram_re   = 1'b1;
            end
            default: begin
                ram_addr = 16'h0000;
                ram_we   = 1'b0;
                ram_re   = 1'b0;
                ram_din  = 8'h00;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            abl_q       <= 8'h00;
            abh_q       <= 8'h00;
            result_q    <= 8'h00;
            error_q     <= 1'b0;
            cap_q       <= 1'b0;
            ld_rst_q    <= 1'b1;
            ld_load_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
            cpu_rdy_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            abl_q       <= abl_d;
            abh_q       <= abh_d;
            result_q    <= result_d;
            error_q     <= error_d;
            cap_q       <= cap_d;
            ld_rst_q    <= ld_rst_d;
            ld_load_q   <= ld_load_d;
            cpu_reset_q <= cpu_reset_d;
            cpu_rdy_q   <= cpu_rdy_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ld_rst    = ld_rst_q;
    assign ld_load   = ld_load_q;
    assign cpu_reset = cpu_reset_q;
    assign cpu_rdy   = cpu_rdy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign result    = result_q;
    assign state     = state_q;

endmodule

// File: tb/tb_harness_sequencer.sv
// Scoreboard bench for harness_sequencer: stimulus pushes expected state entries, RAM accesses and
// output snapshots into queues; a negedge monitor pops and compares them as the DUT produces them.
module tb_harness_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] ld_addr;
    logic        ld_we;
    logic [7:0]  ld_data;
    logic        ld_done;
    logic        ld_rst;
    logic        ld_load;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [2:0]  cpu_lh;
    logic        cpu_reset;
    logic        cpu_rdy;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic        ram_re;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [7:0]  result;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  state;

    harness_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .ld_addr(ld_addr), .ld_we(ld_we), .ld_data(ld_data), .ld_done(ld_done),
        .ld_rst(ld_rst), .ld_load(ld_load),
        .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_lh(cpu_lh),
        .cpu_reset(cpu_reset), .cpu_rdy(cpu_rdy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re), .ram_din(ram_din),
        .ram_dout(ram_dout), .result(result),
        .busy(busy), .done(done), .error(error), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: registered read, one cycle latency.
    bit [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic [2:0] st;
        int         dur;
        logic       err;
        logic       dn;
        logic       bz;
        int         rdy;
        int         re;
        bit         ram;
    } st_exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    typedef struct {
        string       name;
        logic [43:0] v;
        bit          st_only;
    } snap_t;

    st_exp_t     exp_st_q[$];
    wr_exp_t     exp_wr_q[$];
    logic [15:0] exp_rd_q[$];
    snap_t       snap_q[$];

    int n_checks = 0;
    int n_errors = 0;
    bit end_req  = 1'b0;
    bit end_ack  = 1'b0;

    function automatic logic [43:0] outs_now();
        return {state, ld_rst, ld_load, cpu_reset, cpu_rdy, busy, done, error, result,
                ram_we, ram_re, ram_addr, ram_din};
    endfunction

    function automatic logic [43:0] mk_idle(input logic [7:0] res);
        return {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, res, 1'b0, 1'b0, 16'h0000, 8'h00};
    endfunction

    function automatic logic [43:0] mk_done(input logic err, input logic [7:0] res);
        return {3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, err, res, 1'b0, 1'b0, 16'h0000, 8'h00};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic exp_st(input logic [2:0] st, input int dur, input logic err, input logic dn,
                          input logic bz, input int rdy, input int re, input bit ram);
        st_exp_t e;
        e.st = st; e.dur = dur; e.err = err; e.dn = dn; e.bz = bz;
        e.rdy = rdy; e.re = re; e.ram = ram;
        exp_st_q.push_back(e);
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
        wr_exp_t w;
        w.addr = a; w.data = d;
        exp_wr_q.push_back(w);
    endtask

    task automatic push_snap(input string nm, input logic [43:0] v, input bit st_only);
        snap_t s;
        s.name = nm; s.v = v; s.st_only = st_only;
        snap_q.push_back(s);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait; an expired budget becomes a state comparison the monitor will flag.
    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            step(1);
            n++;
        end
        if (state !== s) push_snap(tag, {s, 41'd0}, 1'b1);
    endtask

    task automatic cpu_cycle(input logic [2:0] lh, input logic [7:0] d, input logic we);
        cpu_lh = lh; cpu_do = d; cpu_we = we;
        step(1);
    endtask

    task automatic frame_wr(input logic [15:0] a, input logic [7:0] d);
        logic [15:0] av;
        av = a;
        cpu_cycle(3'd0, av[7:0], 1'b0);
        cpu_cycle(3'd1, 8'h00, 1'b0);
        cpu_cycle(3'd2, av[15:8], 1'b0);
        cpu_cycle(3'd4, 8'h00, 1'b0);
        cpu_cycle(3'd5, d, 1'b1);
        cpu_lh = 3'd7; cpu_do = 8'h00; cpu_we = 1'b0;
    endtask

    task automatic frame_rd(input logic [15:0] a);
        logic [15:0] av;
        av = a;
        cpu_cycle(3'd0, av[7:0], 1'b0);
        cpu_cycle(3'd2, av[15:8], 1'b0);
        cpu_cycle(3'd3, 8'h00, 1'b0);
        cpu_lh = 3'd7; cpu_do = 8'h00; cpu_we = 1'b0;
    endtask

    // Monitor: compares everything the DUT presents at each falling edge.
    initial begin
        logic [2:0] prev_st = 3'd0;
        int         dur_cnt = 0;
        int         rdy_cnt = 0;
        int         re_cnt  = 0;
        st_exp_t    e;
        wr_exp_t    w;
        snap_t      s;
        logic [15:0] ra;
        forever begin
            @(negedge clk);
            if (state !== prev_st) begin
                if (exp_st_q.size() == 0) begin
                    chk($sformatf("state_unexpected_%0d", state), exp_st_q.size(), 1);
                end else begin
                    e = exp_st_q.pop_front();
                    chk("state_seq", state, e.st);
                    if (e.dur >= 0) chk($sformatf("cycles_before_st%0d", e.st), dur_cnt, e.dur);
                    chk($sformatf("error_at_st%0d", e.st), error, e.err);
                    chk($sformatf("done_at_st%0d", e.st), done, e.dn);
                    chk($sformatf("busy_at_st%0d", e.st), busy, e.bz);
                    if (e.rdy >= 0) chk("cpu_rdy_cycles", rdy_cnt, e.rdy);
                    if (e.re >= 0) chk("run_read_count", re_cnt, e.re);
                    if (e.ram) chk("dump_ram_port", {ram_addr, ram_re, ram_we}, {16'hE200, 1'b1, 1'b0});
                end
                if (state == 3'd1) begin
                    rdy_cnt = 0;
                    re_cnt  = 0;
                end
                dur_cnt = 1;
            end else begin
                dur_cnt++;
            end
            if (cpu_rdy === 1'b1) rdy_cnt++;
            if (ram_re === 1'b1 && state == 3'd4) begin
                re_cnt++;
                if (exp_rd_q.size() == 0) begin
                    chk("read_unexpected", exp_rd_q.size(), 1);
                end else begin
                    ra = exp_rd_q.pop_front();
                    chk("read_addr", ram_addr, ra);
                end
            end
            if (ram_we === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    chk("write_unexpected", exp_wr_q.size(), 1);
                end else begin
                    w = exp_wr_q.pop_front();
                    chk("write_addr_data", {ram_addr, ram_din}, {w.addr, w.data});
                end
            end
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                if (s.st_only) chk(s.name, state, s.v[43:41]);
                else           chk(s.name, {20'd0, outs_now()}, {20'd0, s.v});
            end
            if (end_req && !end_ack) begin
                chk("states_left", exp_st_q.size(), 0);
                chk("writes_left", exp_wr_q.size(), 0);
                chk("reads_left", exp_rd_q.size(), 0);
                chk("snaps_left", snap_q.size(), 0);
                end_ack = 1'b1;
            end
            prev_st = state;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    // Stimulus.
    initial begin
        int n;
        reset_n = 1'b0; start = 1'b0;
        ld_addr = 16'h0000; ld_we = 1'b0; ld_data = 8'h00; ld_done = 1'b0;
        cpu_do = 8'h00; cpu_we = 1'b0; cpu_lh = 3'd7;
        push_snap("reset_values", mk_idle(8'h00), 1'b0);
        step(2);
        reset_n = 1'b1;
        step(2);

        // Nominal: loader writes 5A to E200, one CPU write and one CPU read, full run.
        exp_st(3'd1, -1,   1'b0, 1'b0, 1'b1, -1,   -1, 1'b0);
        exp_st(3'd2, 8,    1'b0, 1'b0, 1'b1, -1,   -1, 1'b0);
        exp_st(3'd3, 40,   1'b0, 1'b0, 1'b1, -1,   -1, 1'b0);
        exp_st(3'd4, 6,    1'b0, 1'b0, 1'b1, -1,   -1, 1'b0);
        exp_st(3'd5, 2444, 1'b0, 1'b0, 1'b1, 2444, 1,  1'b1);
        exp_st(3'd6, 1,    1'b0, 1'b1, 1'b0, -1,   -1, 1'b0);
        exp_st(3'd0, -1,   1'b0, 1'b0, 1'b0, -1,   -1, 1'b0);
        exp_wr(16'hE200, 8'h5A);
        exp_wr(16'h1234, 8'hC3);
        exp_rd_q.push_back(16'h4321);
        start = 1'b1;
        wait_state(3'd2, 20, "wait_load_nominal");
        for (int i = 1; i < 40; i++) begin
            if (i == 5) begin
                ld_we = 1'b1; ld_addr = 16'hE200; ld_data = 8'h5A;
            end else begin
                ld_we = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00;
            end
            step(1);
        end
        ld_we = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00;
        ld_done = 1'b1;
        step(1);
        ld_done = 1'b0;
        wait_state(3'd4, 20, "wait_run_nominal");
        step(9);
        frame_wr(16'h1234, 8'hC3);
        frame_rd(16'h4321);
        wait_state(3'd6, 2600, "wait_done_nominal");
        step(1);
        push_snap("nominal_done_result", mk_done(1'b0, 8'h5A), 1'b0);
        step(1);
        start = 1'b0;
        step(3);

        // Abort mid-RUN after 100 RUN cycles; result must be held.
        exp_st(3'd1, -1,  1'b0, 1'b0, 1'b1, -1,  -1, 1'b0);
        exp_st(3'd2, 8,   1'b0, 1'b0, 1'b1, -1,  -1, 1'b0);
        exp_st(3'd3, 1,   1'b0, 1'b0, 1'b1, -1,  -1, 1'b0);
        exp_st(3'd4, 6,   1'b0, 1'b0, 1'b1, -1,  -1, 1'b0);
        exp_st(3'd0, 100, 1'b0, 1'b0, 1'b0, 100, 0,  1'b0);
        ld_done = 1'b1;
        start = 1'b1;
        wait_state(3'd4, 40, "wait_run_abort");
        ld_done = 1'b0;
        step(99);
        start = 1'b0;
        step(1);
        push_snap("abort_idle_outputs", mk_idle(8'h5A), 1'b0);
        step(3);

        // Load timeout: ld_done never arrives.
        exp_st(3'd1, -1,   1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
        exp_st(3'd2, 8,    1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
        exp_st(3'd6, 1024, 1'b1, 1'b1, 1'b0, 0,  -1, 1'b0);
        exp_st(3'd0, -1,   1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
        start = 1'b1;
        wait_state(3'd6, 1100, "wait_done_timeout");
        step(1);
        push_snap("timeout_done_outputs", mk_done(1'b1, 8'h5A), 1'b0);
        step(1);
        start = 1'b0;
        step(3);

        // Reset asserted in LOAD cycle 11 while start stays high.
        exp_st(3'd1, -1, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
        exp_st(3'd2, 8,  1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
        exp_st(3'd0, 11, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
        start = 1'b1;
        wait_state(3'd2, 20, "wait_load_reset");
        step(10);
        reset_n = 1'b0;
        step(1);
        push_snap("reset_mid_load", mk_idle(8'h00), 1'b0);
        step(1);
        push_snap("reset_over_start", mk_idle(8'h00), 1'b0);
        start = 1'b0;
        reset_n = 1'b1;
        step(3);

`ifdef HARNESS_SEQ_HALT_ON_RESULT_EN
        // Early halt: write to E200 on RUN cycle 300.
        exp_st(3'd1, -1,  1'b0, 1'b0, 1'b1, -1,  -1, 1'b0);
        exp_st(3'd2, 8,   1'b0, 1'b0, 1'b1, -1,  -1, 1'b0);
        exp_st(3'd3, 1,   1'b0, 1'b0, 1'b1, -1,  -1, 1'b0);
        exp_st(3'd4, 6,   1'b0, 1'b0, 1'b1, -1,  -1, 1'b0);
        exp_st(3'd5, 300, 1'b0, 1'b0, 1'b1, 300, 0,  1'b1);
        exp_st(3'd6, 1,   1'b0, 1'b1, 1'b0, -1,  -1, 1'b0);
        exp_st(3'd0, -1,  1'b0, 1'b0, 1'b0, -1,  -1, 1'b0);
        exp_wr(16'hE200, 8'h77);
        ld_done = 1'b1;
        start = 1'b1;
        wait_state(3'd4, 40, "wait_run_halt");
        ld_done = 1'b0;
        step(295);
        frame_wr(16'hE200, 8'h77);
        wait_state(3'd6, 8, "wait_done_halt");
        step(1);
        push_snap("halt_done_result", mk_done(1'b0, 8'h77), 1'b0);
        step(1);
        start = 1'b0;
        step(3);
`endif

        end_req = 1'b1;
        n = 0;
        while (!end_ack && n < 20) begin
            step(1);
            n++;
        end
        if (!end_ack) begin
            $display("FAIL end_handshake: got no monitor ack, expected ack");
            $fatal(1);
        end
        step(1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/harness_sequencer.md
HARNESS_SEQUENCER -- requirements
Module: harness_sequencer

Interface
REQ-001 Parameter CPU_RST_CYCLES, default 8: number of cycles the CPU and loader reset is held.
REQ-002 Parameter SETTLE_CYCLES, default 6: number of cycles between the end of load and the first RDY.
REQ-003 Parameter RUN_CYCLES, default 2444: number of cycles RDY is held high.
REQ-004 Parameter LOAD_MAX, default 1024: maximum number of LOAD cycles before an error abort.
REQ-005 Parameter RESULT_ADDR, default 16'hE200: RAM address read back after the run.
REQ-006 Ports, listed as name, direction, width, meaning:
- clk, in, 1: single clock; all logic is on the rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- start, in, 1: level; high runs the sequence, low aborts it to IDLE.
- ld_addr / ld_we / ld_data, in, 16 / 1 / 8: loader RAM port.
- ld_done, in, 1: loader finished.
- ld_rst / ld_load, out, 1 / 1: loader reset and loader enable.
- cpu_do / cpu_we / cpu_lh, in, 8 / 1 / 3: serialized CPU data out, write enable and phase.
- cpu_reset / cpu_rdy, out, 1 / 1: CPU reset and CPU ready.
- ram_addr / ram_we / ram_re / ram_din, out, 16 / 1 / 1 / 8: the single RAM port.
- ram_dout, in, 8: RAM read data, available 1 cycle after ram_re.
- result, out, 8: captured result byte.
- busy / done / error, out, 1 / 1 / 1: status flags.
- state, out, 3: current state encoding.

Function
REQ-007 The FSM SHALL use these states and encodings: IDLE=0, CPURST=1, LOAD=2, SETTLE=3, RUN=4, DUMP=5, DONE=6; the `state` output SHALL show the current state.
REQ-008 In IDLE, when start=1, the FSM SHALL clear its phase counter and go to CPURST.
REQ-009 In CPURST, ld_rst and cpu_reset SHALL be 1 for exactly CPU_RST_CYCLES cycles, then the FSM SHALL go to LOAD.
REQ-010 In LOAD:
- ld_load=1 and cpu_reset=1.
- The RAM port SHALL be driven from ld_addr, ld_we and ld_data, with ram_re=0.
- ld_done=1 SHALL move the FSM to SETTLE.
- If LOAD_MAX cycles pass without ld_done, error SHALL be set to 1 and the FSM SHALL go to DONE.
REQ-011 In SETTLE, cpu_reset=0 and cpu_rdy=0 for SETTLE_CYCLES cycles, then the FSM SHALL go to RUN.
REQ-012 In RUN, cpu_rdy=1 for exactly RUN_CYCLES cycles, counted from the first RUN cycle; the FSM SHALL then go to DUMP.
REQ-013 The CPU address SHALL be rebuilt from the serialized output:
- Register abl <= cpu_do when cpu_lh==0.
- Register abh <= cpu_do when cpu_lh==2.
- Both SHALL update in every state except IDLE and CPURST, where they are cleared to 0.
REQ-014 In RUN:
- ram_addr = {abh, abl}.
- we_g = cpu_we & (cpu_lh==5) & cpu_rdy; ram_we = we_g.
- ram_re = !we_g & (cpu_lh==3) & cpu_rdy.
- ram_din = cpu_do.
- Write has priority over read.
REQ-015 In DUMP:
- cpu_rdy=0, ram_addr=RESULT_ADDR, ram_re=1, ram_we=0.
- DUMP SHALL last exactly 1 cycle, then the FSM SHALL go to DONE.
- On the first DONE cycle, result <= ram_dout.
REQ-016 In DONE, done=1 and the FSM SHALL hold while start=1; start=0 SHALL return it to IDLE and clear done and error.
REQ-017 If start=0 in any state other than IDLE or DONE, the FSM SHALL abort to IDLE on the next edge; all outputs SHALL return to their reset values except result, which is held.
REQ-018 busy SHALL be 1 in the states CPURST through DUMP.
REQ-019 In any state other than LOAD, RUN or DUMP: ram_we=0, ram_re=0, ram_addr=0, ram_din=0.
REQ-020 The phase counter SHALL be 32 bits wide, reload to 0 on every state change, and never wrap inside a state.

Reset
REQ-021 When reset_n=0 on a clock edge:
- state <= IDLE.
- Counters, abl, abh, result, done and error <= 0.
- ld_rst=1 and cpu_reset=1; all other outputs 0.
REQ-022 Reset SHALL take priority over start and ld_done; asserting reset mid-RUN SHALL drop cpu_rdy on the next edge.

Configuration
REQ-023 Macro HARNESS_SEQ_HALT_ON_RESULT_EN:
- When defined, a RUN cycle with ram_we=1 and ram_addr==RESULT_ADDR SHALL end RUN early; the FSM SHALL go to DUMP on the next edge, and the write itself SHALL complete.
- When undefined, RUN SHALL always last RUN_CYCLES cycles.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Nominal: start=1, ld_done after 40 LOAD cycles, ram_dout=8'h5A in DUMP -> states sequence 1,2,3,4,5,6; cpu_rdy high for exactly 2444 cycles; result=8'h5A; done=1.
- Load timeout: ld_done never asserts -> DONE after 1024 LOAD cycles with error=1, cpu_rdy never 1.
- Address rebuild: in RUN, cpu_do=8'h34 at lh=0, 8'h12 at lh=2, cpu_we=1 at lh=5 -> exactly 1 write at 16'h1234; no ram_re in that frame.
- Abort: start=0 mid-RUN -> next edge state=0, cpu_rdy=0, busy=0.
- Reset mid-LOAD: reset_n=0 -> state=0, ld_rst=1, cpu_reset=1, error=0.
- With HARNESS_SEQ_HALT_ON_RESULT_EN defined: a write to 16'hE200 at RUN cycle 300 -> DUMP on the next edge, done before cycle 310.
